// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, err_o bit positions, timeout counter width.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Sticky error flag positions in err_o.
    localparam int ERR_DROP    = 0;
    localparam int ERR_TIMEOUT = 1;

    // WAIT-cycle counter width; TIMEOUT must fit below 2**TMO_W.
    localparam int TMO_W = 16;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Round-robin picker: first set bit of pend_i strictly after last_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld_o low when nothing is pending.
// Ports: pend_i (pending mask), last_i (previous grant) -> grant_o (index), vld_o.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               vld_o
);

    int               sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        // Scan last+1 .. last+NUM_REQ so the previous winner is checked last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = (int'(last_i) + off) % NUM_REQ;
            idx = IDX_W'(sum);
            if (!found && pend_i[idx]) begin
                found   = 1'b1;
                grant_o = idx;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one simple_ddr3 port between NUM_REQ requesters.
// Latency: strobe in cycle N -> DRAM strobe in cycle N+2 when idle; read ack is combinational from dram_ack_i.
// Backpressure: one pending slot per requester; strobes while occupied are dropped (err_o[0]); grants wait for dram_busy_i=0.
// Ports: req_* requester side (packed per requester), dram_* to/from simple_ddr3, err_o sticky {timeout, drop}.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0]        req_pop_i,
    output logic [DATA_W-1:0]         req_data_o,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [NUM_REQ-1:0]        req_busy_o,
    output logic [ADDR_W-1:0]         dram_addr_o,
    output logic [DATA_W-1:0]         dram_data_o,
    output logic                      dram_we_o,
    output logic                      dram_pop_o,
    input  logic [DATA_W-1:0]         dram_data_i,
    input  logic                      dram_ack_i,
    input  logic                      dram_busy_i,
    output logic [1:0]                err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q;
    logic [NUM_REQ-1:0] pend_q;
    logic [NUM_REQ-1:0] wr_q;
    logic [ADDR_W-1:0]  addr_q [NUM_REQ];
    logic [DATA_W-1:0]  data_q [NUM_REQ];
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [1:0]         err_q;
    logic [ADDR_W-1:0]  dram_addr_q;
    logic [DATA_W-1:0]  dram_data_q;
    logic               dram_we_q;
    logic               dram_pop_q;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .pend_i  (pend_q),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .vld_o   (pick_vld)
    );

    // Completion decode. rst gates WAIT so an abandoned read never acks.
    logic in_wait, tmo_hit, cur_wr, rd_done, wr_done, done, tmo_err;

    assign in_wait = (state_q == ST_WAIT) && !rst;
    assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign cur_wr  = wr_q[grant_q];
    assign rd_done = in_wait && !cur_wr && (dram_ack_i || tmo_hit);
    assign wr_done = in_wait && cur_wr && (!dram_busy_i || tmo_hit);
    assign done    = rd_done || wr_done;
    // A genuine completion in the last allowed cycle is not a timeout.
    assign tmo_err = tmo_hit && !(cur_wr ? !dram_busy_i : dram_ack_i);

    always_comb begin
        req_ack_o = '0;
        if (rd_done) begin
            req_ack_o[grant_q] = 1'b1;
        end
    end

    assign req_data_o = rd_done ? (dram_ack_i ? dram_data_i : '1) : '0;

    // Strobe acceptance: a slot completing this cycle is free for a re-strobe.
    logic [NUM_REQ-1:0] stb, slot_free;
    logic               drop_err, both_err;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            stb[k]       = req_we_i[k] | req_pop_i[k];
            slot_free[k] = !pend_q[k] || (done && (grant_q == IDX_W'(k)));
        end
        drop_err = |(stb & ~slot_free);
        both_err = |(req_we_i & req_pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            wr_q        <= '0;
            grant_q     <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            tmo_q       <= '0;
            err_q       <= '0;
            dram_addr_q <= '0;
            dram_data_q <= '0;
            dram_we_q   <= 1'b0;
            dram_pop_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (done && (grant_q == IDX_W'(k))) begin
                    pend_q[k] <= 1'b0;
                end
                // Load after the clear so a re-strobe in the completion cycle wins.
                if (stb[k] && slot_free[k]) begin
                    pend_q[k] <= 1'b1;
                    wr_q[k]   <= req_we_i[k];
                    addr_q[k] <= req_addr_i[k*ADDR_W +: ADDR_W];
                    data_q[k] <= req_data_i[k*DATA_W +: DATA_W];
                end
            end

            err_q[ERR_DROP]    <= err_q[ERR_DROP] | drop_err | both_err;
            err_q[ERR_TIMEOUT] <= err_q[ERR_TIMEOUT] | tmo_err;

            // DRAM strobes are single-cycle: set on entry to ISSUE only.
            dram_we_q  <= 1'b0;
            dram_pop_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (pick_vld && !dram_busy_i) begin
                        grant_q     <= pick_idx;
                        last_q      <= pick_idx;
                        dram_addr_q <= addr_q[pick_idx];
                        dram_data_q <= data_q[pick_idx];
                        dram_we_q   <= wr_q[pick_idx];
                        dram_pop_q  <= !wr_q[pick_idx];
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        tmo_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_busy_o  = pend_q;
    assign dram_addr_o = dram_addr_q;
    assign dram_data_o = dram_data_q;
    assign dram_we_o   = dram_we_q;
    assign dram_pop_o  = dram_pop_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: inputs driven on negedge, outputs checked #1 later.
// Latency: n/a.
// Backpressure: n/a; bench plays the DRAM by driving dram_ack_i/dram_busy_i directly.
module tb_dram_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ-1:0]        req_pop_i;
    logic [DATA_W-1:0]         req_data_o;
    logic [NUM_REQ-1:0]        req_ack_o;
    logic [NUM_REQ-1:0]        req_busy_o;
    logic [ADDR_W-1:0]         dram_addr_o;
    logic [DATA_W-1:0]         dram_data_o;
    logic                      dram_we_o;
    logic                      dram_pop_o;
    logic [DATA_W-1:0]         dram_data_i;
    logic                      dram_ack_i;
    logic                      dram_busy_i;
    logic [1:0]                err_o;

    always #5 clk = ~clk;

    dram_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_we_i    (req_we_i),
        .req_pop_i   (req_pop_i),
        .req_data_o  (req_data_o),
        .req_ack_o   (req_ack_o),
        .req_busy_o  (req_busy_o),
        .dram_addr_o (dram_addr_o),
        .dram_data_o (dram_data_o),
        .dram_we_o   (dram_we_o),
        .dram_pop_o  (dram_pop_o),
        .dram_data_i (dram_data_i),
        .dram_ack_i  (dram_ack_i),
        .dram_busy_i (dram_busy_i),
        .err_o       (err_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
        req_addr_i[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_data(input int k, input logic [DATA_W-1:0] d);
        req_data_i[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_inputs();
        req_addr_i  = '0;
        req_data_i  = '0;
        req_we_i    = '0;
        req_pop_i   = '0;
        dram_data_i = '0;
        dram_ack_i  = 1'b0;
        dram_busy_i = 1'b0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        clear_inputs();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int             ops;
    int             n_ack;
    logic           pend_ack;
    logic [1:0]     exp_ack;

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Drive garbage on DRAM data to show req_data_o stays gated in reset.
        dram_data_i = 32'hcafef00d;
        nxt();
        nxt();
        #1;
        check("rst_busy", req_busy_o, 0);
        check("rst_err",  err_o, 0);
        check("rst_we",   dram_we_o, 0);
        check("rst_pop",  dram_pop_o, 0);
        check("rst_ack",  req_ack_o, 0);
        check("rst_rdat", req_data_o, 0);
        check("rst_addr", dram_addr_o, 0);
        check("rst_wdat", dram_data_o, 0);

        // Single read: pop at N+2, ack 5 cycles later.
        do_reset();
        nxt();                                  // N
        set_addr(0, 28'h1234567);
        req_pop_i = 2'b01;
        #1 check("rd_busy_n", req_busy_o, 2'b00);
        nxt();                                  // N+1
        req_pop_i = 2'b00;
        #1 check("rd_busy_n1", req_busy_o, 2'b01);
        check("rd_pop_n1", dram_pop_o, 0);
        nxt();                                  // N+2
        #1 check("rd_pop_n2", dram_pop_o, 1);
        check("rd_we_n2", dram_we_o, 0);
        check("rd_addr", dram_addr_o, 28'h1234567);
        nxt();                                  // N+3
        #1 check("rd_pop_n3", dram_pop_o, 0);
        repeat (3) nxt();                       // N+6
        #1 check("rd_noack", req_ack_o, 2'b00);
        nxt();                                  // N+7
        dram_ack_i  = 1'b1;
        dram_data_i = 32'h12345678;
        #1 check("rd_ack", req_ack_o, 2'b01);
        check("rd_data", req_data_o, 32'h12345678);
        nxt();                                  // N+8
        dram_ack_i = 1'b0;
        #1 check("rd_ack_off", req_ack_o, 2'b00);
        check("rd_busy_end", req_busy_o, 2'b00);
        check("rd_err", err_o, 2'b00);

        // Contention: simultaneous writes, req0 served first.
        do_reset();
        nxt();                                  // N
        set_addr(0, 28'h00000a0);
        set_addr(1, 28'h00000b1);
        set_data(0, 32'h0a0a0a0a);
        set_data(1, 32'h1b1b1b1b);
        req_we_i = 2'b11;
        nxt();                                  // N+1
        req_we_i = 2'b00;
        #1 check("ct_busy1", req_busy_o, 2'b11);
        nxt();                                  // N+2
        #1 check("ct_we0", dram_we_o, 1);
        check("ct_addr0", dram_addr_o, 28'h00000a0);
        check("ct_data0", dram_data_o, 32'h0a0a0a0a);
        nxt();                                  // N+3: WAIT, busy low -> req0 done
        #1 check("ct_we_off", dram_we_o, 0);
        nxt();                                  // N+4
        #1 check("ct_busy4", req_busy_o, 2'b10);
        nxt();                                  // N+5
        #1 check("ct_we1", dram_we_o, 1);
        check("ct_addr1", dram_addr_o, 28'h00000b1);
        check("ct_data1", dram_data_o, 32'h1b1b1b1b);
        nxt();                                  // N+6
        nxt();                                  // N+7
        #1 check("ct_busy7", req_busy_o, 2'b00);
        check("ct_noack", req_ack_o, 2'b00);

        // Fairness: both re-strobe reads in their completion cycle.
        do_reset();
        nxt();
        set_addr(0, 28'h0000100);
        set_addr(1, 28'h0000200);
        req_pop_i = 2'b11;
        n_ack    = 0;
        pend_ack = 1'b0;
        exp_ack  = 2'b01;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            nxt();
            req_pop_i   = 2'b00;
            dram_ack_i  = pend_ack;
            dram_data_i = 32'ha0000000 | 32'(c);
            pend_ack    = 1'b0;
            #1;
            if (dram_pop_o) begin
                check("fair_addr", dram_addr_o, exp_ack[0] ? 28'h0000100 : 28'h0000200);
                pend_ack = 1'b1;
            end
            if (req_ack_o != 2'b00) begin
                check("fair_ack", req_ack_o, exp_ack);
                check("fair_data", req_data_o, 32'ha0000000 | 32'(c));
                n_ack++;
                exp_ack   = ~exp_ack;
                req_pop_i = req_ack_o;
            end
        end
        check("fair_count", n_ack, 4);

        // Overrun: second write strobe from req1 while busy is dropped.
        do_reset();
        nxt();                                  // N
        set_addr(1, 28'h0000abc);
        set_data(1, 32'hdeadbeef);
        req_we_i = 2'b10;
        nxt();                                  // N+1
        set_addr(1, 28'h0000def);
        set_data(1, 32'h0badf00d);
        #1 check("ov_busy", req_busy_o, 2'b10);
        nxt();                                  // N+2
        req_we_i = 2'b00;
        #1 check("ov_we", dram_we_o, 1);
        check("ov_addr", dram_addr_o, 28'h0000abc);
        check("ov_data", dram_data_o, 32'hdeadbeef);
        check("ov_err", err_o, 2'b01);
        ops = 0;
        for (int c = 0; c < 8; c++) begin
            nxt();
            #1;
            if (dram_we_o || dram_pop_o) ops++;
        end
        check("ov_ops", ops, 0);
        check("ov_busy_end", req_busy_o, 2'b00);
        check("ov_err_end", err_o, 2'b01);

        // we and pop together: treated as write, flagged.
        do_reset();
        nxt();
        set_addr(0, 28'h0000777);
        req_we_i  = 2'b01;
        req_pop_i = 2'b01;
        nxt();
        req_we_i  = 2'b00;
        req_pop_i = 2'b00;
        nxt();                                  // N+2
        #1 check("both_we", dram_we_o, 1);
        check("both_pop", dram_pop_o, 0);
        check("both_err", err_o, 2'b01);

        // Timeout: no DRAM ack; forced all-ones ack in the 16th WAIT cycle.
        do_reset();
        nxt();                                  // N
        set_addr(0, 28'h0000321);
        req_pop_i = 2'b01;
        nxt();
        req_pop_i = 2'b00;
        nxt();                                  // N+2
        #1 check("to_pop", dram_pop_o, 1);
        repeat (15) nxt();                      // N+17
        #1 check("to_early", req_ack_o, 2'b00);
        nxt();                                  // N+18
        #1 check("to_ack", req_ack_o, 2'b01);
        check("to_data", req_data_o, 32'hffffffff);
        nxt();                                  // N+19
        #1 check("to_err", err_o, 2'b10);
        check("to_busy", req_busy_o, 2'b00);
        check("to_ack_off", req_ack_o, 2'b00);

        // Reset while in WAIT: no ack, stray ack ignored, next read normal.
        do_reset();
        nxt();                                  // N
        set_addr(0, 28'h0000444);
        req_pop_i = 2'b01;
        nxt();
        req_pop_i = 2'b00;
        nxt();                                  // N+2
        #1 check("rw_pop", dram_pop_o, 1);
        nxt();                                  // N+3
        nxt();                                  // N+4
        rst         = 1'b1;
        dram_ack_i  = 1'b1;
        dram_data_i = 32'h11111111;
        #1 check("rw_noack_rst", req_ack_o, 2'b00);
        nxt();                                  // N+5
        rst        = 1'b0;
        dram_ack_i = 1'b0;
        #1 check("rw_busy", req_busy_o, 2'b00);
        check("rw_noack", req_ack_o, 2'b00);
        nxt();                                  // N+6: ack outside WAIT
        dram_ack_i = 1'b1;
        #1 check("rw_stray", req_ack_o, 2'b00);
        nxt();                                  // N+7
        dram_ack_i = 1'b0;
        set_addr(0, 28'h0000555);
        req_pop_i = 2'b01;
        nxt();
        req_pop_i = 2'b00;
        nxt();                                  // N+9
        #1 check("rw_pop2", dram_pop_o, 1);
        check("rw_addr2", dram_addr_o, 28'h0000555);
        nxt();                                  // N+10
        dram_ack_i  = 1'b1;
        dram_data_i = 32'h5555aaaa;
        #1 check("rw_ack2", req_ack_o, 2'b01);
        check("rw_data2", req_data_o, 32'h5555aaaa);
        nxt();
        dram_ack_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requester ports.
REQ-002 SHALL have parameter ADDR_W, default 28: DRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 32: DRAM data width.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum WAIT cycles before forced completion.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_addr_i  in  NUM_REQ*ADDR_W  packed per-requester address; requester k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_data_i  in  NUM_REQ*DATA_W  packed per-requester write data.
REQ-009 SHALL have port req_we_i  in  NUM_REQ  one-cycle write strobe per requester.
REQ-010 SHALL have port req_pop_i  in  NUM_REQ  one-cycle read strobe per requester.
REQ-011 SHALL have port req_data_o  out  DATA_W  read data, shared; valid only with req_ack_o.
REQ-012 SHALL have port req_ack_o  out  NUM_REQ  one-cycle read-completion pulse per requester.
REQ-013 SHALL have port req_busy_o  out  NUM_REQ  requester k has an accepted, uncompleted request.
REQ-014 SHALL have ports dram_addr_o (ADDR_W), dram_data_o (DATA_W), dram_we_o (1) and dram_pop_o (1), all out, driving the simple_ddr3 addr_i/data_i/we_i/pop_i.
REQ-015 SHALL have ports dram_data_i (DATA_W), dram_ack_i (1) and dram_busy_i (1), all in, from the simple_ddr3 data_o/ack_o/busy_o.
REQ-016 SHALL have port err_o  out  2  sticky flags: [0] strobe dropped, [1] timeout.

Function
REQ-017 SHALL hold one pending slot per requester (addr, data, is_write); a strobe while req_busy_o[k]=0 loads the slot in the same edge, and req_busy_o[k] is high from the next cycle.
REQ-018 SHALL ignore a strobe while req_busy_o[k]=1 and set err_o[0].
REQ-019 SHALL treat req_we_i and req_pop_i high together as a write and set err_o[0].
REQ-020 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-021 IDLE SHALL grant, when any slot is pending and dram_busy_i=0, the first pending requester after last_grant (round-robin), register the grant, and move to ISSUE.
REQ-022 ISSUE SHALL drive the granted slot onto dram_addr_o/dram_data_o, pulse dram_we_o or dram_pop_o for exactly one cycle, and move to WAIT.
REQ-023 WAIT for a read SHALL, on dram_ack_i=1, present dram_data_i on req_data_o, pulse req_ack_o[grant] in that cycle (combinational pass-through), clear the slot, and return to IDLE.
REQ-024 WAIT for a write SHALL complete on the first cycle with dram_busy_i=0 at least one cycle after ISSUE, clearing the slot without any ack, and return to IDLE.
REQ-025 SHALL give a latency from requester strobe (cycle N) to DRAM strobe of N+2 when idle and uncontended.
REQ-026 SHALL count WAIT cycles; at TIMEOUT it SHALL force completion, with reads acking req_data_o = all-ones, set err_o[1], and return to IDLE.
REQ-027 SHALL drive dram_we_o and dram_pop_o to 0 outside ISSUE, and req_ack_o to 0 outside read completion.
REQ-028 SHALL allow a completing requester to re-strobe in the completion cycle (its slot frees on the same edge).
REQ-029 SHALL ignore dram_ack_i outside WAIT.
REQ-030 SHALL never grant a requester twice in a row while another requester is pending.

Reset
REQ-031 On rst, the FSM SHALL be IDLE, all slots cleared, last_grant = NUM_REQ-1 (requester 0 first), the timeout counter 0, err_o 0, and all outputs 0.
REQ-032 A reset mid-operation SHALL abandon the in-flight request with no req_ack_o.

Structure
REQ-033 Package dram_arb_pkg SHALL hold the FSM state encoding, the err_o bit indices and the timeout counter width.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs: pending mask, last_grant; outputs: grant index, valid).

Verification
REQ-035 Single read: req0 pops addr 28'h1234567, DRAM acks 5 cycles after pop with 32'h12345678 -> dram_pop_o at N+2; req_ack_o=2'b01 with data 32'h12345678.
REQ-036 Contention: req0 and req1 strobe writes in the same cycle -> DRAM sees req0 then req1; req_busy_o clears in that order.
REQ-037 Fairness: both requesters issue continuous back-to-back reads -> grants alternate 0,1,0,1.
REQ-038 Overrun: req1 strobes twice while busy -> second strobe dropped, err_o=2'b01, a single DRAM op.
REQ-039 Timeout: dram_ack_i held 0, TIMEOUT=16 -> ack after 16 WAIT cycles with 32'hffffffff, err_o[1]=1.
REQ-040 Reset in WAIT -> no ack, req_busy_o=0, the next request is served normally.
